demux1to4_stream: RTL and testbench
===================================

Name: demux1to4_stream

Overview:
- Registered, flow-controlled 1-to-4 demultiplexer. Routes a WIDTH-bit data word to one of four output channels, selected by a 2-bit select.
- Each channel has a one-entry output register with a valid/ready handshake, so a stalled consumer blocks only traffic aimed at its own channel.
- Sits downstream of the data source and upstream of four independent consumers. It is the buffered, clocked stage of the combinational gate-level demux.

Parameters:
WIDTH, 8, data word width in bits (>=1)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  source presents a word
in_ready  output  1  block can accept the word on in_sel this cycle
in_data  input  WIDTH  word to route
in_sel  input  2  destination; in_sel[1]=a (MSB), in_sel[0]=b (LSB); 0->ch0, 1->ch1, 2->ch2, 3->ch3
out_valid  output  4  bit k: channel k holds a valid word
out_ready  input  4  bit k: consumer k accepts this cycle
out_data0..out_data3  output  WIDTH each  channel k held word

Behaviour:
- Reset: rst=1 at a rising edge clears out_valid to 4'b0000, out_data0..3 to 0, and counters (if built) to 0. Reset mid-transfer discards held words with no delivery. in_ready is 0 while rst=1.
- Clock and reset: one clock. Reset is synchronous and active-high.
- in_ready is combinational: in_ready = ~rst & (~out_valid[in_sel] | out_ready[in_sel]). It depends only on the selected channel.
- Accept: in_valid & in_ready at an edge loads in_data into channel in_sel and sets out_valid[in_sel]. Latency is 1 cycle from accept to out_valid.
- Deliver: out_valid[k] & out_ready[k] at an edge removes the word. out_valid[k] clears unless a new word loads into k on the same edge.
- Simultaneous deliver and load on the same channel: load wins. out_valid stays 1 and out_dataK takes the new word. Throughput is 1 word/cycle per channel with no bubble.
- Full channel: out_valid[k]=1, out_ready[k]=0 and in_sel=k forces in_ready=0. The source must hold in_data/in_sel stable until accepted. Other channels keep draining independently.
- in_sel and in_data are don't-care when in_valid=0. No state changes without a handshake.
- Once out_valid[k]=1, out_dataK is stable until delivered.
- Channels never reorder: each carries only words addressed to it, in arrival order (depth 1).
- No state machine beyond the per-channel full/empty bit. Each channel is EMPTY->FULL on load, and FULL->EMPTY on deliver-without-load.

Optional Feature:
- Macro: DEMUX1TO4_STREAM_CNT_EN.
- When defined, the block adds output port cnt_ch of width 32 (four 8-bit fields, channel k at bits [8k+7:8k]).
- Each field counts words delivered (out_valid&out_ready) on its channel and wraps 255->0.
- The counters reset to 0 with rst.
- When not defined, the port and counters are absent. All other behaviour is identical.

Test Plan:
1. Reset then idle: rst=1 two cycles, then rst=0 -> out_valid=0000, all out_data=0, in_ready=1 for any in_sel.
2. Route each channel: out_ready=1111, send 8'hA0/0, 8'hA1/1, 8'hA2/2, 8'hA3/3 back-to-back -> each word appears on its own channel one cycle after accept, with a single out_valid bit set per cycle.
3. Backpressure isolation: out_ready=1110. Send 8'h11 to ch0 -> out_valid[0]=1 and held. Send 8'h22 to ch0 -> in_ready=0 and the word is held. Send 8'h33 to ch2 -> accepted; ch2 delivers next cycle. Raise out_ready[0] -> 8'h11 delivered, then 8'h22 accepted.
4. Simultaneous deliver+load: ch1 holding 8'h55 with out_ready[1]=1 while 8'h66 arrives for ch1 -> next cycle out_valid[1]=1 and out_data1=8'h66, with no idle cycle.
5. Reset mid-operation: ch3 holding 8'h77 with out_ready=0, assert rst for one cycle -> out_valid[3]=0 and out_data3=0; 8'h77 is never delivered.
6. With DEMUX1TO4_STREAM_CNT_EN: deliver 257 words to ch2 -> cnt_ch[23:16]=1, other fields 0.

Source files
------------

// File: rtl/demux1to4_stream_if.sv
// Handshake bundle for demux1to4_stream: one input stream and four output channels.
// slave is the demux side, master is the source/consumer side.
interface demux1to4_stream_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
    );

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
    );
endinterface

// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demux with a one-entry valid/ready register per channel.
// Optional DEMUX1TO4_STREAM_CNT_EN adds cnt_ch: four 8-bit wrapping delivered-word counters.
module demux1to4_stream #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    demux1to4_stream_if.slave     bus
`ifdef DEMUX1TO4_STREAM_CNT_EN
    ,
    output logic [31:0]           cnt_ch
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    logic [3:0] full_vec;
    logic [3:0] load_vec;
    logic [3:0] deliver_vec;
    logic       in_ready_int;

    // A word may enter when its target channel is empty or is draining on this same edge.
    assign in_ready_int = ~rst & (~full_vec[bus.in_sel] | bus.out_ready[bus.in_sel]);
    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = full_vec;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : ch
            ch_state_t        state_reg;
            ch_state_t        state_next;
            logic [WIDTH-1:0] data_reg;

            assign full_vec[gi]    = (state_reg == FULL);
            assign load_vec[gi]    = bus.in_valid & in_ready_int & (bus.in_sel == 2'(gi));
            assign deliver_vec[gi] = full_vec[gi] & bus.out_ready[gi];

            // Load takes priority so a simultaneous drain and refill leaves no bubble.
            always_comb begin
                state_next = state_reg;
                if (load_vec[gi]) begin
                    state_next = FULL;
                end else if (deliver_vec[gi]) begin
                    state_next = EMPTY;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= EMPTY;
                    data_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    if (load_vec[gi]) begin
                        data_reg <= bus.in_data;
                    end
                end
            end

`ifdef DEMUX1TO4_STREAM_CNT_EN
            logic [7:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= 8'd0;
                end else if (deliver_vec[gi]) begin
                    cnt_reg <= cnt_reg + 8'd1;
                end
            end

            assign cnt_ch[8*gi +: 8] = cnt_reg;
`endif
        end
    endgenerate

    assign bus.out_data0 = ch[0].data_reg;
    assign bus.out_data1 = ch[1].data_reg;
    assign bus.out_data2 = ch[2].data_reg;
    assign bus.out_data3 = ch[3].data_reg;

endmodule

// File: tb/tb_demux1to4_stream.sv
// Directed, table-driven bench for demux1to4_stream plus hand-written burst and counter sequences.
module tb_demux1to4_stream;

    logic clk;
    logic rst;
`ifdef DEMUX1TO4_STREAM_CNT_EN
    logic [31:0] cnt_ch;
`endif

    demux1to4_stream_if #(.WIDTH(8)) bus ();

    demux1to4_stream #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave)
`ifdef DEMUX1TO4_STREAM_CNT_EN
        ,
        .cnt_ch (cnt_ch)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [1:0]  sel;
        logic [7:0]  data;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_vld;
        logic [31:0] exp_data;   // {d3,d2,d1,d0}; checked where exp_vld is set, or all lanes on reset rows
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    function automatic vec_t mk(logic r, logic v, logic [1:0] s, logic [7:0] d, logic [3:0] o,
                                logic er, logic [3:0] ev, logic [31:0] ed);
        vec_t t;
        t.rst = r; t.vld = v; t.sel = s; t.data = d; t.ordy = o;
        t.exp_rdy = er; t.exp_vld = ev; t.exp_data = ed;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [7:0] d [4];
        logic [3:0] mask;
        rst           = v.rst;
        bus.in_valid  = v.vld;
        bus.in_sel    = v.sel;
        bus.in_data   = v.data;
        bus.out_ready = v.ordy;
        #1;
        check($sformatf("v%0d_in_ready", idx), 32'(bus.in_ready), 32'(v.exp_rdy));
        tick();
        check($sformatf("v%0d_out_valid", idx), 32'(bus.out_valid), 32'(v.exp_vld));
        d[0] = bus.out_data0;
        d[1] = bus.out_data1;
        d[2] = bus.out_data2;
        d[3] = bus.out_data3;
        mask = v.rst ? 4'b1111 : v.exp_vld;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) begin
                check($sformatf("v%0d_out_data%0d", idx, k), 32'(d[k]), 32'(v.exp_data[8*k +: 8]));
            end
        end
        $display("vec %0d: rst=%0b vld=%0b sel=%0d data=%h ordy=%b -> in_ready=%0b out_valid=%b",
                 idx, v.rst, v.vld, v.sel, v.data, v.ordy, bus.in_ready, bus.out_valid);
    endtask

    initial begin
        rst = 1'b1; bus.in_valid = 1'b0; bus.in_sel = 2'd0; bus.in_data = 8'h00; bus.out_ready = 4'b0000;

        // reset, then idle on every select
        vecs.push_back(mk(1, 0, 0, 8'h00, 4'b0000, 0, 4'b0000, 32'h0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 4'b0000, 0, 4'b0000, 32'h0));
        for (int s = 0; s < 4; s++)
            vecs.push_back(mk(0, 0, 2'(s), 8'h00, 4'b0000, 1, 4'b0000, 32'h0));
        // route each channel back-to-back
        vecs.push_back(mk(0, 1, 0, 8'hA0, 4'b1111, 1, 4'b0001, 32'h000000A0));
        vecs.push_back(mk(0, 1, 1, 8'hA1, 4'b1111, 1, 4'b0010, 32'h0000A100));
        vecs.push_back(mk(0, 1, 2, 8'hA2, 4'b1111, 1, 4'b0100, 32'h00A20000));
        vecs.push_back(mk(0, 1, 3, 8'hA3, 4'b1111, 1, 4'b1000, 32'hA3000000));
        vecs.push_back(mk(0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000, 32'h0));
        // backpressure isolation on ch0
        vecs.push_back(mk(0, 1, 0, 8'h11, 4'b1110, 1, 4'b0001, 32'h00000011));
        vecs.push_back(mk(0, 1, 0, 8'h22, 4'b1110, 0, 4'b0001, 32'h00000011));
        vecs.push_back(mk(0, 1, 2, 8'h33, 4'b1110, 1, 4'b0101, 32'h00330011));
        vecs.push_back(mk(0, 1, 0, 8'h22, 4'b1110, 0, 4'b0001, 32'h00000011));
        vecs.push_back(mk(0, 1, 0, 8'h22, 4'b1111, 1, 4'b0001, 32'h00000022));
        vecs.push_back(mk(0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000, 32'h0));
        // simultaneous deliver and load on ch1
        vecs.push_back(mk(0, 1, 1, 8'h55, 4'b0000, 1, 4'b0010, 32'h00005500));
        vecs.push_back(mk(0, 1, 1, 8'h66, 4'b0010, 1, 4'b0010, 32'h00006600));
        vecs.push_back(mk(0, 0, 1, 8'h00, 4'b0010, 1, 4'b0000, 32'h0));
        // no change without handshake; stalled ch2 does not block ch0
        vecs.push_back(mk(0, 1, 2, 8'h5A, 4'b0000, 1, 4'b0100, 32'h005A0000));
        vecs.push_back(mk(0, 0, 2, 8'hFF, 4'b0000, 0, 4'b0100, 32'h005A0000));
        vecs.push_back(mk(0, 1, 0, 8'hC3, 4'b0000, 1, 4'b0101, 32'h005A00C3));
        vecs.push_back(mk(0, 0, 0, 8'h00, 4'b0101, 1, 4'b0000, 32'h0));
        // reset while ch3 holds an undelivered word
        vecs.push_back(mk(0, 1, 3, 8'h77, 4'b0000, 1, 4'b1000, 32'h77000000));
        vecs.push_back(mk(1, 0, 0, 8'h00, 4'b0000, 0, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 0, 3, 8'h00, 4'b1111, 1, 4'b0000, 32'h0));

        foreach (vecs[i]) apply(vecs[i], i);

        // sustained one-word-per-cycle stream into ch1
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 8'(8'h80 + i); bus.out_ready = 4'b1111;
            #1;
            check($sformatf("burst%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
            tick();
            check($sformatf("burst%0d_out_valid", i), 32'(bus.out_valid), 32'b0010);
            check($sformatf("burst%0d_out_data1", i), 32'(bus.out_data1), 32'(8'h80 + i));
            $display("burst %0d: data=%h out_valid=%b out_data1=%h", i, bus.in_data, bus.out_valid, bus.out_data1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("burst_drain_out_valid", 32'(bus.out_valid), 32'b0000);

`ifdef DEMUX1TO4_STREAM_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("cnt_after_reset", cnt_ch, 32'h0);
        for (int i = 0; i < 257; i++) begin
            bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 8'(i); bus.out_ready = 4'b1111;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        check("cnt_after_257_ch2", cnt_ch, 32'h00010000);
        $display("counter: cnt_ch=%h after 257 words on ch2", cnt_ch);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
